// File: rtl/branch_predictor_pkg.sv
// Shared pipeline constants plus the BTB entry and direction-counter types.
package branch_predictor_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_ctr_e;

  // The tag field is sized for the widest legal tag; bits above TAG_BITS stay zero.
  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] tag;
    logic [DATA_WIDTH-1:0] target;
    bp_ctr_e               ctr;
  } bp_entry_t;

  function automatic logic [DATA_WIDTH-1:0] bp_tag(input logic [DATA_WIDTH-1:0] pc,
                                                   input int unsigned idx_bits,
                                                   input int unsigned tag_bits);
    logic [DATA_WIDTH-1:0] mask;
    mask = (DATA_WIDTH'(1) << tag_bits) - DATA_WIDTH'(1);
    return (pc >> (idx_bits + 2)) & mask;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Two-bit saturating up/down counter next-state logic.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (inc && !dec && (cur != STRONG_T)) begin
      nxt = cur + 2'd1;
    end else if (dec && !inc && (cur != STRONG_NT)) begin
      nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB next-PC predictor with 2-bit direction counters and statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned TAG_BITS   = 10,
  parameter int unsigned STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_valid,
  input  logic [DATA_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] pred_pcn,
  output logic                  pred_taken,
  input  logic                  upd_valid,
  input  logic [DATA_WIDTH-1:0] upd_pc,
  input  logic                  upd_is_branch,
  input  logic                  upd_is_jump,
  input  logic                  upd_taken,
  input  logic [DATA_WIDTH-1:0] upd_target,
  input  logic                  upd_mispredict,
  output logic [STAT_WIDTH-1:0] stat_lookups,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int unsigned IDX_BITS = $clog2(ENTRIES);

  bp_entry_t btb_q [ENTRIES];

  logic [IDX_BITS-1:0]   lk_idx;
  logic [DATA_WIDTH-1:0] lk_tag;
  bp_entry_t             lk_entry;
  logic                  lk_hit;

  logic [IDX_BITS-1:0]   upd_idx;
  logic [DATA_WIDTH-1:0] upd_tag;
  bp_entry_t             upd_entry;
  bp_entry_t             new_entry;
  logic                  upd_hit;
  logic                  upd_we;
  logic [1:0]            ctr_nxt;

  logic [STAT_WIDTH-1:0] stat_lookups_q;
  logic [STAT_WIDTH-1:0] stat_mispredicts_q;

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign lk_idx     = if_pc[IDX_BITS+1:2];
  assign lk_tag     = bp_tag(if_pc, IDX_BITS, TAG_BITS);
  assign lk_entry   = btb_q[lk_idx];
  assign lk_hit     = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign pred_taken = lk_hit && lk_entry.ctr[1];
  assign pred_pcn   = pred_taken ? lk_entry.target : (if_pc + DATA_WIDTH'(4));

  assign upd_idx   = upd_pc[IDX_BITS+1:2];
  assign upd_tag   = bp_tag(upd_pc, IDX_BITS, TAG_BITS);
  assign upd_entry = btb_q[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  bp_sat_counter u_sat_counter (
    .cur (upd_entry.ctr),
    .inc (upd_taken),
    .dec (!upd_taken),
    .nxt (ctr_nxt)
  );

  always_comb begin
    upd_we    = 1'b0;
    new_entry = upd_entry;
    if (upd_valid && (upd_is_branch || upd_is_jump)) begin
      if (upd_taken) begin
        upd_we           = 1'b1;
        new_entry.valid  = 1'b1;
        new_entry.tag    = upd_tag;
        new_entry.target = upd_target;
        if (upd_hit) begin
          new_entry.ctr = bp_ctr_e'(ctr_nxt);
        end else begin
          new_entry.ctr = upd_is_jump ? STRONG_T : WEAK_T;
        end
      end else if (upd_hit) begin
        upd_we        = 1'b1;
        new_entry.ctr = bp_ctr_e'(ctr_nxt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
      end
    end else if (upd_we) begin
      btb_q[upd_idx] <= new_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (if_valid && !(&stat_lookups_q)) begin
        stat_lookups_q <= stat_lookups_q + STAT_WIDTH'(1);
      end
      if (upd_valid && upd_mispredict && !(&stat_mispredicts_q)) begin
        stat_mispredicts_q <= stat_mispredicts_q + STAT_WIDTH'(1);
      end
    end
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with a narrow statistics width.
module tb_branch_predictor;

  localparam int unsigned SW = 4;

  logic          clk;
  logic          rst_n;
  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   pred_pcn;
  logic          pred_taken;
  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic          upd_is_branch;
  logic          upd_is_jump;
  logic          upd_taken;
  logic [31:0]   upd_target;
  logic          upd_mispredict;
  logic [SW-1:0] stat_lookups;
  logic [SW-1:0] stat_mispredicts;

  int n_checks;
  int n_fail;

  localparam logic [31:0] PC_A = 32'h8000_0010;
  localparam logic [31:0] PC_B = 32'h8000_0050;
  localparam logic [31:0] PC_C = 32'h8000_0020;

  branch_predictor #(
    .ENTRIES    (16),
    .TAG_BITS   (10),
    .STAT_WIDTH (SW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .pred_pcn         (pred_pcn),
    .pred_taken       (pred_taken),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_is_branch    (upd_is_branch),
    .upd_is_jump      (upd_is_jump),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .stat_lookups     (stat_lookups),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic br, input logic jp, input logic tk,
                     input logic [31:0] tgt);
    upd_valid     = 1'b1;
    upd_pc        = pc;
    upd_is_branch = br;
    upd_is_jump   = jp;
    upd_taken     = tk;
    upd_target    = tgt;
  endtask

  task automatic upd_clear();
    upd_valid      = 1'b0;
    upd_is_branch  = 1'b0;
    upd_is_jump    = 1'b0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  // Apply one update, then look up the given PC and compare the prediction.
  task automatic step(input string name, input logic [31:0] pc, input logic br, input logic tk,
                      input logic [31:0] tgt, input logic exp_taken, input logic [31:0] exp_pcn);
    upd(pc, br, 1'b0, tk, tgt);
    tick();
    upd_clear();
    if_pc = pc;
    #1;
    check({name, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
    check({name, "_pcn"}, pred_pcn, exp_pcn);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    if_valid = 1'b0;
    if_pc    = 32'h8000_0000;
    upd_pc   = '0;
    upd_target = '0;
    upd_clear();
    #1;
    check("rst_taken", {31'd0, pred_taken}, 32'd0);
    check("rst_pcn", pred_pcn, 32'h8000_0004);
    check("rst_lookups", {28'd0, stat_lookups}, 32'd0);
    check("rst_mispredicts", {28'd0, stat_mispredicts}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    if_valid = 1'b1;
    tick();
    if_valid = 1'b0;
    check("lookups_one", {28'd0, stat_lookups}, 32'd1);
    check("idle_pcn", pred_pcn, 32'h8000_0004);

    // Allocation as WEAK_T, climb to STRONG_T with saturation, then decay to STRONG_NT.
    step("alloc", PC_A, 1'b1, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_0100);
    step("inc1", PC_A, 1'b1, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_0100);
    step("inc2", PC_A, 1'b1, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_0100);
    step("dec1", PC_A, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0100);
    step("dec2", PC_A, 1'b1, 1'b0, 32'h0, 1'b0, 32'h8000_0014);
    step("dec3", PC_A, 1'b1, 1'b0, 32'h0, 1'b0, 32'h8000_0014);
    step("rise1", PC_A, 1'b1, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_0014);
    step("rise2", PC_A, 1'b1, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_0100);

    // Same index, different tag.
    if_pc = PC_B;
    #1;
    check("alias_taken", {31'd0, pred_taken}, 32'd0);
    check("alias_pcn", pred_pcn, 32'h8000_0054);

    // Jump wins over branch: allocation lands at STRONG_T, survives one not-taken.
    upd(PC_B, 1'b1, 1'b1, 1'b1, 32'h8000_0200);
    tick();
    upd_clear();
    check("jump_pcn", pred_pcn, 32'h8000_0200);
    step("jump_dec", PC_B, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0200);
    if_pc = PC_A;
    #1;
    check("evicted_pcn", pred_pcn, 32'h8000_0014);

    // Same-cycle lookup and update on one index: old target now, new target next cycle.
    if_pc = PC_B;
    upd(PC_B, 1'b1, 1'b0, 1'b1, 32'h8000_0300);
    #1;
    check("same_cycle_old", pred_pcn, 32'h8000_0200);
    tick();
    upd_clear();
    check("same_cycle_new", pred_pcn, 32'h8000_0300);

    // Not-taken miss and non-control-flow updates never allocate.
    upd(PC_C, 1'b1, 1'b0, 1'b0, 32'h8000_0400);
    tick();
    upd(PC_C, 1'b0, 1'b0, 1'b1, 32'h8000_0400);
    tick();
    upd_clear();
    if_pc = PC_C;
    #1;
    check("nt_miss_pcn", pred_pcn, 32'h8000_0024);
    if_pc = PC_B;
    #1;
    check("unchanged_pcn", pred_pcn, 32'h8000_0300);
    check("lookups_still_one", {28'd0, stat_lookups}, 32'd1);
    check("mispredicts_zero", {28'd0, stat_mispredicts}, 32'd0);

    // Mispredict counting ignores the table rule but requires upd_valid.
    for (int i = 0; i < 3; i++) begin
      upd_valid      = 1'b1;
      upd_mispredict = 1'b1;
      tick();
    end
    upd_valid = 1'b0;
    tick();
    upd_clear();
    check("mispredicts_three", {28'd0, stat_mispredicts}, 32'd3);

    for (int i = 0; i < 20; i++) begin
      upd_valid      = 1'b1;
      upd_mispredict = 1'b1;
      if_valid       = 1'b1;
      tick();
    end
    upd_clear();
    if_valid = 1'b0;
    check("mispredicts_sat", {28'd0, stat_mispredicts}, 32'd15);
    check("lookups_sat", {28'd0, stat_lookups}, 32'd15);

    // Asynchronous reset with an update pending: effects appear without a clock edge.
    upd(PC_A, 1'b1, 1'b1, 1'b1, 32'h8000_0500);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_lookups", {28'd0, stat_lookups}, 32'd0);
    check("arst_mispredicts", {28'd0, stat_mispredicts}, 32'd0);
    check("arst_b_taken", {31'd0, pred_taken}, 32'd0);
    check("arst_b_pcn", pred_pcn, 32'h8000_0054);
    tick();
    upd_clear();
    rst_n = 1'b1;
    if_pc = PC_A;
    #1;
    check("arst_discard_pcn", pred_pcn, 32'h8000_0014);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
